// File: rtl/y86_mem_if.sv
// Data-memory handshake between the M stage, the data memory and the
// pipeline controller (request, completion, forced timeout).
interface y86_mem_if;
    logic mem_req;
    logic mem_ack;
    logic mem_timeout;

    modport master (
        output mem_req,
        output mem_ack,
        input  mem_timeout
    );

    modport slave (
        input  mem_req,
        input  mem_ack,
        output mem_timeout
    );
endinterface

// File: rtl/y86_pipe_ctrl.sv
// Y86-64 pipeline control: hazards, variable-latency memory wait, halt latch.
// Define PIPE_PERF_EN to build the cycle/stall/bubble performance counters.
module y86_pipe_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_Cnd,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    y86_mem_if.slave         mem,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_stall,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             W_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [7:0] TO_LIM = 8'(MEM_TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} st_t;

    st_t        state_q;
    logic [7:0] wcnt_q;
    logic       halted_q;

    logic load_use, ret_pend, mispred;
    logic exc_m, exc_w;
    logic mem_wait, tmo;

    assign exc_m = (m_stat == 3'd2) | (m_stat == 3'd3) | (m_stat == 3'd4);
    assign exc_w = (W_stat == 3'd2) | (W_stat == 3'd3) | (W_stat == 3'd4);

    assign load_use = ((E_icode == 4'h5) | (E_icode == 4'hB))
                    & ((E_dstM == d_srcA) | (E_dstM == d_srcB))
                    & (E_dstM != 4'hF);
    assign ret_pend = (D_icode == 4'h9) | (E_icode == 4'h9)
                    | (M_icode == 4'h9);
    assign mispred  = (E_icode == 4'h7) & ~e_Cnd;

    assign tmo = (state_q == S_WAIT) & (wcnt_q == TO_LIM)
               & mem.mem_req & ~mem.mem_ack;
    assign mem_wait = mem.mem_req & ~mem.mem_ack & ~tmo & ~halted_q;

    assign mem.mem_timeout = tmo;
    assign halted          = halted_q;

    always_comb begin
        F_stall  = load_use | ret_pend;
        D_stall  = load_use;
        D_bubble = mispred | (~load_use & ret_pend);
        E_bubble = mispred | load_use;
        M_bubble = exc_m | exc_w;
        W_stall  = exc_w;
        M_stall  = 1'b0;
        W_bubble = 1'b0;
        // E holds through M_stall, so a wait freezes F..M and drains W.
        if (mem_wait) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            M_stall  = 1'b1;
            W_bubble = 1'b1;
            D_bubble = 1'b0;
            E_bubble = 1'b0;
            M_bubble = 1'b0;
            W_stall  = 1'b0;
        end
        if (halted_q) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            M_bubble = 1'b1;
            W_stall  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wcnt_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_q | exc_w;
            unique case (state_q)
                S_IDLE: begin
                    if (mem_wait) begin
                        state_q <= S_WAIT;
                        wcnt_q  <= 8'd1;
                    end else begin
                        wcnt_q  <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem.mem_ack | tmo | ~mem.mem_req) begin
                        state_q <= S_IDLE;
                        wcnt_q  <= '0;
                    end else begin
                        wcnt_q  <= wcnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    wcnt_q  <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_EN
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cyc_q, stl_q, bub_q;

    // Counters saturate instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_q <= '0;
            stl_q <= '0;
            bub_q <= '0;
        end else if (!halted_q) begin
            if (cyc_q != '1)
                cyc_q <= cyc_q + ONE;
            if (F_stall && (stl_q != '1))
                stl_q <= stl_q + ONE;
            if ((D_bubble | E_bubble | W_bubble) && (bub_q != '1))
                bub_q <= bub_q + ONE;
        end
    end

    assign cycle_cnt  = cyc_q;
    assign stall_cnt  = stl_q;
    assign bubble_cnt = bub_q;
`else
    assign cycle_cnt  = '0;
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// Testbench for y86_pipe_ctrl: directed plan steps plus random traffic
// checked every cycle against a rule-level reference model.
module tb_y86_pipe_ctrl;

    localparam int CW = 8;
    localparam int TO = 4;
    localparam longint MAXC = (64'd1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [3:0]    D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB;
    logic          e_Cnd;
    logic [2:0]    m_stat, W_stat;
    logic          F_stall, D_stall, D_bubble, E_bubble;
    logic          M_stall, M_bubble, W_stall, W_bubble, halted;
    logic [CW-1:0] cycle_cnt, stall_cnt, bubble_cnt;

    y86_mem_if mif ();

    y86_pipe_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat),
        .mem(mif),
        .F_stall(F_stall), .D_stall(D_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .W_stall(W_stall), .W_bubble(W_bubble),
        .halted(halted),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_tot  = 0;

    // Reference state: "waiting" flag with cycles waited so far.
    bit     m_busy;
    int     m_waited;
    bit     m_halt;
    longint m_cyc, m_stl, m_bub;

    function automatic bit exc(logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    function automatic longint sat(longint v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_tot++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic quiet();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
        e_Cnd = 1'b1; m_stat = 3'd1; W_stat = 3'd1;
        mif.mem_req = 1'b0; mif.mem_ack = 1'b0;
        reset = 1'b0;
    endtask

    // One cycle: check outputs mid-cycle, then advance the model at the edge.
    task automatic cyc();
        bit lu, rp, mp, tmo, mw;
        bit eF, eD, eDb, eEb, eMs, eMb, eWs, eWb;
        longint ec, es, eb;
        bit req, ack;
        req = mif.mem_req;
        ack = mif.mem_ack;
        lu = (E_icode == 4'h5 || E_icode == 4'hB)
          && (E_dstM == d_srcA || E_dstM == d_srcB) && E_dstM != 4'hF;
        rp = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
        mp = (E_icode == 4'h7) && !e_Cnd;
        tmo = m_busy && (m_waited == TO) && req && !ack;
        mw = req && !ack && !tmo && !m_halt;
        if (mw) begin
            eF = 1; eD = 1; eMs = 1; eWb = 1;
            eDb = 0; eEb = 0; eMb = 0; eWs = 0;
        end else begin
            eF = lu || rp; eD = lu;
            eDb = mp || (!lu && rp); eEb = mp || lu;
            eMb = exc(m_stat) || exc(W_stat); eWs = exc(W_stat);
            eMs = 0; eWb = 0;
        end
        if (m_halt) begin
            eF = 1; eD = 1; eWs = 1; eMb = 1;
        end
`ifdef PIPE_PERF_EN
        ec = m_cyc; es = m_stl; eb = m_bub;
`else
        ec = 0; es = 0; eb = 0;
`endif
        #1;
        chk("F_stall", 64'(F_stall), 64'(eF));
        chk("D_stall", 64'(D_stall), 64'(eD));
        chk("D_bubble", 64'(D_bubble), 64'(eDb));
        chk("E_bubble", 64'(E_bubble), 64'(eEb));
        chk("M_stall", 64'(M_stall), 64'(eMs));
        chk("M_bubble", 64'(M_bubble), 64'(eMb));
        chk("W_stall", 64'(W_stall), 64'(eWs));
        chk("W_bubble", 64'(W_bubble), 64'(eWb));
        chk("mem_timeout", 64'(mif.mem_timeout), 64'(tmo));
        chk("halted", 64'(halted), 64'(m_halt));
        chk("cycle_cnt", 64'(cycle_cnt), 64'(ec));
        chk("stall_cnt", 64'(stall_cnt), 64'(es));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(eb));
        @(posedge clock);
        if (reset) begin
            m_busy = 0; m_waited = 0; m_halt = 0;
            m_cyc = 0; m_stl = 0; m_bub = 0;
        end else begin
            if (!m_halt) begin
                m_cyc = sat(m_cyc + 1);
                if (eF) m_stl = sat(m_stl + 1);
                if (eDb || eEb || eWb) m_bub = sat(m_bub + 1);
            end
            m_halt = m_halt || exc(W_stat);
            if (!m_busy) begin
                m_busy   = mw;
                m_waited = mw ? 1 : 0;
            end else if (ack || tmo || !req) begin
                m_busy = 0; m_waited = 0;
            end else begin
                m_waited++;
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    logic [3:0] icodes [7] = '{4'h1, 4'h5, 4'hB, 4'h9, 4'h7, 4'h2, 4'h6};

    initial begin
        m_busy = 0; m_waited = 0; m_halt = 0;
        m_cyc = 0; m_stl = 0; m_bub = 0;
        quiet();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cyc();
        reset = 1'b0;

        // Load-use
        E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;
        #1;
        chk("lu_F", 64'(F_stall), 64'd1);
        chk("lu_D", 64'(D_stall), 64'd1);
        chk("lu_Eb", 64'(E_bubble), 64'd1);
        chk("lu_Db", 64'(D_bubble), 64'd0);
        cyc();

        // Ret for three cycles, counters from a fresh reset
        do_reset();
        D_icode = 4'h9;
        repeat (3) begin
            #1;
            chk("ret_F", 64'(F_stall), 64'd1);
            chk("ret_Db", 64'(D_bubble), 64'd1);
            cyc();
        end
        quiet();
        #1;
`ifdef PIPE_PERF_EN
        chk("ret_stl", 64'(stall_cnt), 64'd3);
        chk("ret_bub", 64'(bubble_cnt), 64'd3);
`else
        chk("ret_stl", 64'(stall_cnt), 64'd0);
        chk("ret_bub", 64'(bubble_cnt), 64'd0);
`endif
        cyc();

        // Mispredict alongside a pending ret
        E_icode = 4'h7; e_Cnd = 1'b0; M_icode = 4'h9;
        #1;
        chk("mp_Db", 64'(D_bubble), 64'd1);
        chk("mp_Eb", 64'(E_bubble), 64'd1);
        cyc();
        quiet();

        // Ack on the 4th cycle
        mif.mem_req = 1'b1;
        repeat (3) begin
            #1;
            chk("dly_Ms", 64'(M_stall), 64'd1);
            chk("dly_Wb", 64'(W_bubble), 64'd1);
            cyc();
        end
        mif.mem_ack = 1'b1;
        #1;
        chk("dly_Ms_end", 64'(M_stall), 64'd0);
        cyc();
        quiet();
        cyc();

        // No ack: timeout after TO stall cycles
        mif.mem_req = 1'b1;
        repeat (TO) cyc();
        #1;
        chk("tmo_pulse", 64'(mif.mem_timeout), 64'd1);
        chk("tmo_Ms", 64'(M_stall), 64'd0);
        cyc();
        mif.mem_req = 1'b0;
        cyc();

        // Flushed access, then a zero-wait access
        mif.mem_req = 1'b1;
        repeat (2) cyc();
        mif.mem_req = 1'b0;
        cyc();
        mif.mem_req = 1'b1; mif.mem_ack = 1'b1;
        #1;
        chk("zw_Ms", 64'(M_stall), 64'd0);
        cyc();
        quiet();

        // Reset mid-wait, then a full wait from scratch
        mif.mem_req = 1'b1;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (TO + 2) cyc();
        quiet();
        cyc();

        // Halt latch
        W_stat = 3'd2;
        cyc();
        W_stat = 3'd1;
        #1;
        chk("halt_set", 64'(halted), 64'd1);
        chk("halt_Ws", 64'(W_stall), 64'd1);
        repeat (4) cyc();
        do_reset();
        #1;
        chk("halt_clr", 64'(halted), 64'd0);
        chk("cyc_clr", 64'(cycle_cnt), 64'd0);
        cyc();

        // Long run to reach counter saturation
        D_icode = 4'h9;
        repeat (300) cyc();
        quiet();
        cyc();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            D_icode = icodes[$urandom_range(6, 0)];
            E_icode = icodes[$urandom_range(6, 0)];
            M_icode = icodes[$urandom_range(6, 0)];
            E_dstM  = ($urandom_range(7, 0) == 0) ? 4'hF
                                                  : 4'($urandom_range(3, 0));
            d_srcA  = 4'($urandom_range(3, 0));
            d_srcB  = ($urandom_range(3, 0) == 0) ? 4'hF
                                                  : 4'($urandom_range(3, 0));
            e_Cnd   = 1'($urandom_range(1, 0));
            m_stat  = ($urandom_range(15, 0) == 0) ? 3'($urandom_range(4, 0))
                                                   : 3'd1;
            W_stat  = ($urandom_range(60, 0) == 0) ? 3'($urandom_range(4, 2))
                                                   : 3'd1;
            mif.mem_req = ($urandom_range(3, 0) != 0);
            mif.mem_ack = ($urandom_range(4, 0) == 0);
            reset = ($urandom_range(40, 0) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
